multiword_add_sequencer: RTL

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

---
 rtl/multiword_add_sequencer_pkg.sv | 19 +
 rtl/multiword_add_sequencer_csa.sv | 33 +++
 rtl/multiword_add_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and constants for the multiword add/subtract sequencer.
// One 16-bit slice is processed per clock, least significant slice first.
package multiword_add_sequencer_pkg;

  localparam int SLICE_W = 16;
  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow: operands agree in sign but the result sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_csa.sv
// 16-bit carry-select adder built from four 4-bit groups; each group precomputes
// both carry-in cases and the incoming group carry picks one.
module carry_select_adder_4x4
  import multiword_add_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int GROUPS = SLICE_W / GROUP_W;

  logic [GROUPS-1:0][GROUP_W-1:0] sum0;
  logic [GROUPS-1:0][GROUP_W-1:0] sum1;
  logic [GROUPS-1:0]              co0;
  logic [GROUPS-1:0]              co1;
  logic [GROUPS:0]                gc;

  assign gc[0] = cin;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    assign {co0[g], sum0[g]} = {1'b0, x[g*GROUP_W +: GROUP_W]} + {1'b0, y[g*GROUP_W +: GROUP_W]};
    assign {co1[g], sum1[g]} = {1'b0, x[g*GROUP_W +: GROUP_W]} + {1'b0, y[g*GROUP_W +: GROUP_W]}
                               + {{GROUP_W{1'b0}}, 1'b1};
    assign sum[g*GROUP_W +: GROUP_W] = gc[g] ? sum1[g] : sum0[g];
    assign gc[g+1]                   = gc[g] ? co1[g]  : co0[g];
  end

  assign cout = gc[GROUPS];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multiword add/subtract: operands are captured on accept, then one 16-bit slice
// per cycle is pushed through a single shared carry-select adder.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | adding slice idx, carry chained through the carry register
// DONE  | result held with out_valid until out_ready
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                     c_in,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] s,
  output logic                     c_out,
  output logic                     ovf,
  output logic                     busy
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [WORDS-1:0][SLICE_W-1:0]   a_reg;
  logic [WORDS-1:0][SLICE_W-1:0]   b_reg;
  logic [WORDS-1:0][SLICE_W-1:0]   s_words;
  logic                            carry;

  logic [SLICE_W-1:0]              a_slice;
  logic [SLICE_W-1:0]              b_slice;
  logic [SLICE_W-1:0]              sum_slice;
  logic                            sum_cout;
  logic                            last;
  logic                            accept;

  assign a_slice = a_reg[idx];
  assign b_slice = b_reg[idx];
  assign last    = (idx == IDX_W'(WORDS - 1));
  assign s       = s_words;

  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  carry_select_adder_4x4 u_adder (
    .x    (a_slice),
    .y    (b_slice),
    .cin  (carry),
    .sum  (sum_slice),
    .cout (sum_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_words   <= '0;
      carry     <= 1'b0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B once here and seed the carry.
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry     <= sub | c_in;
      idx       <= '0;
      state     <= RUN;
      busy      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          s_words[idx] <= sum_slice;
          carry        <= sum_cout;
          idx          <= idx + 1'b1;
          if (last) begin
            idx       <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            c_out     <= sum_cout;
            ovf       <= signed_ovf(a_slice[SLICE_W-1], b_slice[SLICE_W-1], sum_slice[SLICE_W-1]);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
